// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for the 5-stage core pipeline. It drives
// the enable/clear controls of the IF/ID, ID/EX and EX/MEM pipeline registers
// and selects EX-stage operand forwarding. It also holds the pipeline while
// the multi-cycle mul/div unit (MDU) in EX is busy, aborting on timeout.
//
// Parameters:
//   MDU_TIMEOUT  max cycles spent in MDU_BUSY before a forced abort (>= 2)
//   CNT_W        width of the saturating stall/flush event counters
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs1_D, rs2_D                  source regs of the instruction in ID
//   rs1_E, rs2_E, rd_E            source/dest regs of the instruction in EX
//   memRead_E                     EX instruction is a load
//   pcSrc_E                       taken branch/jump resolved in EX
//   mduStart_E                    MDU op in EX issued this cycle
//   mduDone                       MDU result valid (one-cycle pulse)
//   rd_M, regWrite_M              MEM-stage destination and write enable
//   rd_W, regWrite_W              WB-stage destination and write enable
//   stall_F                       hold PC
//   en_D, clr_D                   IF/ID enable / clear
//   stall_E, clr_E                hold / bubble ID/EX
//   clr_M                         bubble EX/MEM
//   fwdA_E, fwdB_E                operand select: 00 regfile, 10 MEM, 01 WB
//   mduBusy                       FSM is in MDU_BUSY
//   mduErr                        sticky MDU timeout flag
//   stallCnt                      saturating count of cycles with stall_F=1
//   flushCnt                      saturating count of branch flush cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rs1_E,
   input  logic [4:0]       rs2_E,
   input  logic [4:0]       rd_E,
   input  logic             memRead_E,
   input  logic             pcSrc_E,
   input  logic             mduStart_E,
   input  logic             mduDone,
   input  logic [4:0]       rd_M,
   input  logic             regWrite_M,
   input  logic [4:0]       rd_W,
   input  logic             regWrite_W,
   output logic             stall_F,
   output logic             en_D,
   output logic             clr_D,
   output logic             stall_E,
   output logic             clr_E,
   output logic             clr_M,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic             mduBusy,
   output logic             mduErr,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);

   localparam int TMO_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;

   typedef enum logic {
      IDLE     = 1'b0,
      MDU_BUSY = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             lw_stall;
   logic             tmo_hit;
   logic             busy_hold;

   // ---------------- Forwarding (independent of FSM state) ----------------
   always_comb begin
      fwdA_E = 2'b00;
      if (regWrite_M && rd_M != 5'd0 && rd_M == rs1_E)
         fwdA_E = 2'b10;
      else if (regWrite_W && rd_W != 5'd0 && rd_W == rs1_E)
         fwdA_E = 2'b01;
   end

   always_comb begin
      fwdB_E = 2'b00;
      if (regWrite_M && rd_M != 5'd0 && rd_M == rs2_E)
         fwdB_E = 2'b10;
      else if (regWrite_W && rd_W != 5'd0 && rd_W == rs2_E)
         fwdB_E = 2'b01;
   end

   // ---------------- Hazard detection ----------------
   assign lw_stall = memRead_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);

   // The mduDone cycle and the timeout cycle are both evaluated as IDLE, so
   // the hold is only asserted while the MDU is genuinely still working.
   assign tmo_hit   = (state == MDU_BUSY) && !mduDone && (tmo_cnt == TMO_W'(MDU_TIMEOUT - 1));
   assign busy_hold = (state == MDU_BUSY) && !mduDone && !tmo_hit;

   // ---------------- Pipeline controls ----------------
   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else chain can leave a value unassigned (a latch).
   always_comb begin
      stall_F = 1'b0;
      en_D    = 1'b1;
      clr_D   = 1'b0;
      stall_E = 1'b0;
      clr_E   = 1'b0;
      clr_M   = 1'b0;
      if (rst) begin
         clr_D = 1'b1;
         clr_E = 1'b1;
         clr_M = 1'b1;
      end else if (busy_hold) begin
         // Freeze everything up to EX; feed bubbles into MEM.
         stall_F = 1'b1;
         en_D    = 1'b0;
         stall_E = 1'b1;
         clr_M   = 1'b1;
      end else if (pcSrc_E) begin
         // Branch beats load-use: the ID instruction is on the wrong path.
         clr_D = 1'b1;
         clr_E = 1'b1;
      end else if (lw_stall) begin
         stall_F = 1'b1;
         en_D    = 1'b0;
         clr_E   = 1'b1;
      end
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // Start with done in the same cycle is a 1-cycle op; a start
            // coinciding with a branch is squashed by the branch.
            if (mduStart_E && !pcSrc_E && !mduDone)
               state_nxt = MDU_BUSY;
         end
         MDU_BUSY: begin
            if (mduDone || tmo_hit)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mduBusy = (state == MDU_BUSY);

   // ---------------- State, timeout and event counters ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tmo_cnt  <= '0;
         mduErr   <= 1'b0;
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         state <= state_nxt;

         // Held at zero in IDLE, so it is already cleared on entry to MDU_BUSY.
         if (state == MDU_BUSY)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         else
            tmo_cnt <= '0;

         if (tmo_hit)
            mduErr <= 1'b1;

         if (stall_F && stallCnt != '1)
            stallCnt <= stallCnt + CNT_W'(1);

         // A branch only flushes when the pipeline is not held by the MDU.
         if (pcSrc_E && !busy_hold && flushCnt != '1)
            flushCnt <= flushCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Expected control vectors are pushed
// into a scoreboard queue as each step is driven and popped when the outputs
// are sampled on the falling edge. Counters use a small saturating model.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int TMO   = 8;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   // Control vector order: {stall_F, en_D, clr_D, stall_E, clr_E, clr_M}
   localparam logic [5:0] C_RST  = 6'b011011;
   localparam logic [5:0] C_IDLE = 6'b010000;
   localparam logic [5:0] C_LW   = 6'b100010;
   localparam logic [5:0] C_BR   = 6'b011010;
   localparam logic [5:0] C_BUSY = 6'b100101;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic          memRead_E, pcSrc_E, mduStart_E, mduDone, regWrite_M, regWrite_W;
   logic          stall_F, en_D, clr_D, stall_E, clr_E, clr_M;
   logic [1:0]    fwdA_E, fwdB_E;
   logic          mduBusy, mduErr;
   logic [CW-1:0] stallCnt, flushCnt;

   typedef struct {
      string      tag;
      logic [5:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t sb[$];
   int   n_eval = 0;
   int   n_fail = 0;
   int   exp_stall = 0;
   int   exp_flush = 0;

   pipe_hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .memRead_E(memRead_E), .pcSrc_E(pcSrc_E), .mduStart_E(mduStart_E),
      .mduDone(mduDone), .rd_M(rd_M), .regWrite_M(regWrite_M),
      .rd_W(rd_W), .regWrite_W(regWrite_W),
      .stall_F(stall_F), .en_D(en_D), .clr_D(clr_D), .stall_E(stall_E),
      .clr_E(clr_E), .clr_M(clr_M), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
      .mduBusy(mduBusy), .mduErr(mduErr), .stallCnt(stallCnt), .flushCnt(flushCnt)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [5:0] ctl,
                       input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
      exp_t e;
      e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
      sb.push_back(e);
   endtask

   // Sample on the falling edge and compare against the oldest expectation.
   task automatic pop_cmp();
      exp_t e;
      @(negedge clk);
      e = sb.pop_front();
      chk({e.tag, " ctl"},  32'({stall_F, en_D, clr_D, stall_E, clr_E, clr_M}), 32'(e.ctl));
      chk({e.tag, " fwdA"}, 32'(fwdA_E), 32'(e.fa));
      chk({e.tag, " fwdB"}, 32'(fwdB_E), 32'(e.fb));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic busy, input logic err);
      chk({tag, " mduBusy"},  32'(mduBusy), 32'(busy));
      chk({tag, " mduErr"},   32'(mduErr), 32'(err));
      chk({tag, " stallCnt"}, 32'(stallCnt), 32'(exp_stall));
      chk({tag, " flushCnt"}, 32'(flushCnt), 32'(exp_flush));
   endtask

   task automatic clear_inputs();
      rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
      memRead_E = 0; pcSrc_E = 0; mduStart_E = 0; mduDone = 0;
      regWrite_M = 0; regWrite_W = 0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;

      // ---- Reset: controls forced while rst is high ----
      push("reset", C_RST); pop_cmp(); tick();
      rst = 1'b0;
      push("post_reset", C_IDLE); pop_cmp();
      chk_state("post_reset", 1'b0, 1'b0);
      tick();

      // ---- Forwarding ----
      rs1_E = 5'd5; rd_M = 5'd5; regWrite_M = 1; rd_W = 5'd5; regWrite_W = 1;
      push("fwd_mem_prio", C_IDLE, 2'b10, 2'b00); pop_cmp(); tick();
      regWrite_M = 0;
      push("fwd_wb", C_IDLE, 2'b01, 2'b00); pop_cmp(); tick();
      rd_M = 5'd0; rd_W = 5'd0; rs1_E = 5'd0; regWrite_M = 1;
      push("fwd_x0", C_IDLE, 2'b00, 2'b00); pop_cmp(); tick();
      rs2_E = 5'd9; rd_W = 5'd9; rd_M = 5'd3;
      push("fwdB_wb", C_IDLE, 2'b00, 2'b01); pop_cmp(); tick();
      rd_M = 5'd9;
      push("fwdB_mem", C_IDLE, 2'b00, 2'b10); pop_cmp(); tick();
      clear_inputs();

      // ---- Load-use ----
      memRead_E = 1; rd_E = 5'd7; rs2_D = 5'd7;
      push("lw_stall", C_LW); pop_cmp(); tick();
      exp_stall = sat(exp_stall);
      clear_inputs();
      push("lw_release", C_IDLE); pop_cmp();
      chk_state("lw_release", 1'b0, 1'b0);
      tick();
      memRead_E = 1; rd_E = 5'd0; rs1_D = 5'd0;
      push("lw_rd_x0", C_IDLE); pop_cmp(); tick();
      clear_inputs();

      // ---- Branch overrides load-use ----
      memRead_E = 1; rd_E = 5'd7; rs2_D = 5'd7; pcSrc_E = 1;
      push("branch_vs_lw", C_BR); pop_cmp(); tick();
      exp_flush = sat(exp_flush);
      clear_inputs();
      push("branch_after", C_IDLE); pop_cmp();
      chk_state("branch_after", 1'b0, 1'b0);
      tick();

      // ---- MDU: start at cycle 0, done at cycle 4, branch pulse at cycle 2 ----
      mduStart_E = 1;
      push("mdu_c0", C_IDLE); pop_cmp(); tick();
      mduStart_E = 0;
      for (int c = 1; c <= 3; c++) begin
         pcSrc_E = (c == 2);
         push($sformatf("mdu_c%0d", c), C_BUSY); pop_cmp();
         chk($sformatf("mdu_c%0d mduBusy", c), 32'(mduBusy), 32'd1);
         tick();
         exp_stall = sat(exp_stall);
      end
      pcSrc_E = 0; mduDone = 1;
      push("mdu_c4_done", C_IDLE); pop_cmp(); tick();
      mduDone = 0;
      push("mdu_c5", C_IDLE); pop_cmp();
      chk_state("mdu_c5", 1'b0, 1'b0);
      tick();

      // ---- Start and done together: single-cycle op ----
      mduStart_E = 1; mduDone = 1;
      push("mdu_1cyc", C_IDLE); pop_cmp(); tick();
      clear_inputs();
      chk("mdu_1cyc mduBusy", 32'(mduBusy), 32'd0);

      // ---- Start with branch: branch wins ----
      mduStart_E = 1; pcSrc_E = 1;
      push("mdu_vs_branch", C_BR); pop_cmp(); tick();
      exp_flush = sat(exp_flush);
      clear_inputs();
      push("mdu_vs_branch_after", C_IDLE); pop_cmp();
      chk_state("mdu_vs_branch_after", 1'b0, 1'b0);
      tick();

      // ---- Timeout: busy for TMO cycles, released on the last one ----
      mduStart_E = 1;
      push("tmo_start", C_IDLE); pop_cmp(); tick();
      mduStart_E = 0;
      for (int i = 0; i < TMO; i++) begin
         push($sformatf("tmo_b%0d", i), (i == TMO - 1) ? C_IDLE : C_BUSY); pop_cmp();
         chk($sformatf("tmo_b%0d mduBusy", i), 32'(mduBusy), 32'd1);
         tick();
         if (i != TMO - 1) exp_stall = sat(exp_stall);
      end
      for (int i = 0; i < 3; i++) begin
         push($sformatf("tmo_after%0d", i), C_IDLE); pop_cmp();
         chk_state($sformatf("tmo_after%0d", i), 1'b0, 1'b1);
         tick();
      end

      // ---- Stall counter saturation ----
      memRead_E = 1; rd_E = 5'd12; rs1_D = 5'd12;
      for (int i = 0; i < 6; i++) begin
         push($sformatf("sat_lw%0d", i), C_LW); pop_cmp(); tick();
         exp_stall = sat(exp_stall);
      end
      clear_inputs();
      push("sat_done", C_IDLE); pop_cmp();
      chk_state("sat_done", 1'b0, 1'b1);
      chk("sat_at_max", 32'(stallCnt), 32'(CMAX));
      tick();

      // ---- Reset mid-MDU ----
      mduStart_E = 1;
      push("rmdu_start", C_IDLE); pop_cmp(); tick();
      mduStart_E = 0;
      push("rmdu_b1", C_BUSY); pop_cmp(); tick();
      rst = 1'b1;
      push("rmdu_b2_rst", C_RST); pop_cmp(); tick();
      rst = 1'b0;
      exp_stall = 0; exp_flush = 0;
      push("rmdu_after", C_IDLE); pop_cmp();
      chk_state("rmdu_after", 1'b0, 1'b0);
      tick();

      // ---- Normal operation after reset ----
      memRead_E = 1; rd_E = 5'd4; rs1_D = 5'd4;
      push("post_rst_lw", C_LW); pop_cmp(); tick();
      exp_stall = sat(exp_stall);
      clear_inputs();
      push("post_rst_idle", C_IDLE); pop_cmp();
      chk_state("post_rst_idle", 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage core pipeline.
- Drives the enable/clear controls of the IF/ID, ID/EX and EX/MEM pipeline registers: stalls, flushes and bubbles.
- Selects EX-stage operand forwarding.
- Holds the pipeline while a multi-cycle mul/div unit (MDU) in EX is busy, with timeout protection and stall/flush event counters.

Parameters:
- MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced abort (>=2).
- CNT_W, 32, width of the saturating perf counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- rs1_D  in  5  source reg 1 of instr in ID.
- rs2_D  in  5  source reg 2 of instr in ID.
- rs1_E  in  5  source reg 1 of instr in EX.
- rs2_E  in  5  source reg 2 of instr in EX.
- rd_E  in  5  dest reg of instr in EX.
- memRead_E  in  1  instr in EX is a load.
- pcSrc_E  in  1  taken branch/jump resolved in EX.
- mduStart_E  in  1  MDU op in EX issued this cycle.
- mduDone  in  1  MDU result valid (one-cycle pulse).
- rd_M  in  5  dest reg in MEM.
- regWrite_M  in  1  MEM instr writes rd_M.
- rd_W  in  5  dest reg in WB.
- regWrite_W  in  1  WB instr writes rd_W.
- stall_F  out  1  hold PC.
- en_D  out  1  IF/ID enable (=~stall_D).
- clr_D  out  1  IF/ID clear.
- stall_E  out  1  hold ID/EX.
- clr_E  out  1  ID/EX clear (bubble).
- clr_M  out  1  EX/MEM clear (bubble).
- fwdA_E  out  2  00 regfile, 10 from MEM, 01 from WB.
- fwdB_E  out  2  as fwdA_E, for rs2.
- mduBusy  out  1  FSM in MDU_BUSY.
- mduErr  out  1  sticky timeout flag.
- stallCnt  out  CNT_W  cycles with stall_F=1, saturating.
- flushCnt  out  CNT_W  cycles with clr_D=1 due to pcSrc_E, saturating.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, timeout counter=0, mduErr=0, stallCnt=0, flushCnt=0.
  - While rst is high, outputs are combinationally forced: clr_D=clr_E=clr_M=1, stall_F=stall_E=0, en_D=1.
  - Reset mid-MDU aborts the op with no error.
- Forwarding (combinational, independent of state):
  - fwdA_E=10 if regWrite_M && rd_M!=0 && rd_M==rs1_E.
  - Else fwdA_E=01 if regWrite_W && rd_W!=0 && rd_W==rs1_E.
  - Else fwdA_E=00. MEM has priority over WB.
  - fwdB_E uses the same rules with rs2_E.
- Load-use (lwStall): memRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
  - Effect: stall_F=1, en_D=0, clr_E=1.
  - Exactly one cycle; re-evaluated each cycle.
- Branch (IDLE only): pcSrc_E gives clr_D=1, clr_E=1, stall_F=0, en_D=1.
  - Branch overrides lwStall (the ID instr is wrong-path).
  - flushCnt += 1.
- FSM, two states:
  - IDLE -> MDU_BUSY when mduStart_E && !pcSrc_E && !mduDone. Timeout counter is loaded to 0.
  - mduStart_E together with mduDone in the same cycle is a 1-cycle op: stay IDLE, no stall.
  - mduStart_E together with pcSrc_E is illegal; the branch wins and mduStart_E is ignored.
  - MDU_BUSY outputs: stall_F=1, en_D=0, stall_E=1, clr_M=1, clr_D=0, clr_E=0, mduBusy=1. pcSrc_E and lwStall are masked. The counter increments each cycle.
  - MDU_BUSY -> IDLE on mduDone. That cycle is already evaluated as IDLE: no stall, outputs follow the IDLE rules, and the EX result advances next edge.
  - MDU_BUSY -> IDLE on counter==MDU_TIMEOUT-1 without mduDone. mduErr<=1 (sticky until rst), and stall is released in that cycle.
- stallCnt increments on every cycle with stall_F=1 (load-use or MDU) and saturates at all-ones. flushCnt also saturates.
- Default when no condition holds: all clr=0, stalls=0, en_D=1.
- All outputs except the counters, mduBusy and mduErr are combinational from inputs and state. Zero-cycle latency.

Test Plan:
- Forwarding: rs1_E=5, rd_M=5, regWrite_M=1, rd_W=5, regWrite_W=1 -> fwdA_E=10. Then regWrite_M=0 -> 01. Then rd_M=rd_W=0 with rs1_E=0 -> 00.
- Load-use: memRead_E=1, rd_E=7, rs2_D=7 for 1 cycle -> stall_F=1, en_D=0, clr_E=1 that cycle only; stallCnt=1.
- Branch vs load-use: pcSrc_E=1 with the load-use condition above -> clr_D=1, clr_E=1, stall_F=0; flushCnt=1, stallCnt unchanged.
- MDU sequence: mduStart_E=1 at cycle 0, mduDone at cycle 4.
  - Cycles 1-3: mduBusy=1, stall_F=1, stall_E=1, clr_M=1.
  - Cycle 4: all released.
  - stallCnt=3, and pcSrc_E=1 pulsed at cycle 2 has no effect.
- Timeout: MDU_TIMEOUT=8, mduStart_E and never mduDone -> mduBusy high 8 cycles, then IDLE with mduErr=1. mduErr is held until rst, which clears it and both counters.
- Reset mid-MDU: rst=1 at busy cycle 2 -> next cycle state IDLE, mduErr=0. During rst: clr_D=clr_E=clr_M=1, stall_F=0.
